lc4_iter_divider: RTL and testbench

//  Multi-cycle unsigned 16-bit divider producing quotient and remainder for LC4 DIV/MOD.

---
 rtl/lc4_div_pkg.sv | 25 ++
 rtl/lc4_div_step.sv | 26 ++
 rtl/lc4_iter_divider.sv | 121 ++++++++++++
 tb/tb_lc4_iter_divider.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_div_pkg.sv
// Shared types and sizing helpers for the LC4 iterative divider.
// The top and the step module import this package.
package lc4_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEF_WIDTH          = 16;
    localparam int DEF_BITS_PER_CYCLE = 1;

    // LC4 defines x/0 and x%0 as zero, for both quotient and remainder.
    localparam int DIV_ZERO_RESULT = 0;

    function automatic int div_iters(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    function automatic int div_cnt_width(input int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

endpackage

// File: rtl/lc4_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and shift the resulting quotient bit into the shared dividend/quotient word.
module lc4_div_step
    import lc4_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // The shifted partial remainder needs one extra bit before the trial subtract.
    logic [WIDTH:0] w_rem_shift;
    logic           w_fits;

    assign w_rem_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_fits      = (w_rem_shift >= {1'b0, i_divisor});

    // When the divisor fits, the difference is below the divisor and fits in WIDTH bits.
    assign o_rem = w_fits ? (w_rem_shift[WIDTH-1:0] - i_divisor) : w_rem_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/lc4_iter_divider.sv
// Multi-cycle unsigned divider for LC4 DIV/MOD with valid/ready handshakes on both sides.
// Resolves BITS_PER_CYCLE quotient bits per RUN cycle; one operation in flight.
module lc4_iter_divider
    import lc4_div_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int                N         = div_iters(WIDTH, BITS_PER_CYCLE);
    localparam int                CNT_W     = div_cnt_width(N);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0]  ZERO_RES  = WIDTH'(DIV_ZERO_RESULT);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;

    // Element 0 is the registered working state; element k is after k iterations.
    logic [WIDTH-1:0] w_rem_chain [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] w_quo_chain [BITS_PER_CYCLE+1];

    assign w_rem_chain[0] = r_rem;
    assign w_quo_chain[0] = r_quo;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        lc4_div_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .i_rem     (w_rem_chain[g]),
            .i_quo     (w_quo_chain[g]),
            .i_divisor (r_divisor),
            .o_rem     (w_rem_chain[g+1]),
            .o_quo     (w_quo_chain[g+1])
        );
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            // Flush behaves like reset for the datapath; an i_valid in the same cycle is dropped.
            r_state     <= IDLE;
            r_count     <= '0;
            r_divisor   <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_divisor <= i_divisor;
                        r_quo     <= i_dividend;
                        r_rem     <= '0;
                        r_count   <= '0;
                        o_ready   <= 1'b0;
                        if (i_divisor == '0) begin
                            r_state     <= DONE;
                            o_valid     <= 1'b1;
                            o_quotient  <= ZERO_RES;
                            o_remainder <= ZERO_RES;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end

                RUN: begin
                    r_rem   <= w_rem_chain[BITS_PER_CYCLE];
                    r_quo   <= w_quo_chain[BITS_PER_CYCLE];
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_ITER) begin
                        r_state     <= DONE;
                        o_valid     <= 1'b1;
                        o_quotient  <= w_quo_chain[BITS_PER_CYCLE];
                        o_remainder <= w_rem_chain[BITS_PER_CYCLE];
                    end
                end

                DONE: begin
                    // Results stay put until the consumer takes them.
                    if (i_ready) begin
                        r_state     <= IDLE;
                        r_count     <= '0;
                        o_valid     <= 1'b0;
                        o_ready     <= 1'b1;
                        o_quotient  <= '0;
                        o_remainder <= '0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_count     <= '0;
                    o_valid     <= 1'b0;
                    o_ready     <= 1'b1;
                    o_quotient  <= '0;
                    o_remainder <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc4_iter_divider.sv
// Directed self-checking bench for lc4_iter_divider: default build plus a 4-bits-per-cycle build.
module tb_lc4_iter_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_flush, i_ready;
    logic [15:0] i_dividend, i_divisor;
    logic        o_ready, o_valid;
    logic [15:0] o_quotient, o_remainder;

    logic        v4, f4, rdy4;
    logic [15:0] a4, b4;
    logic        o_ready4, o_valid4;
    logic [15:0] q4, r4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lc4_iter_divider #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_quotient(o_quotient), .o_remainder(o_remainder)
    );

    lc4_iter_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(v4), .o_ready(o_ready4),
        .i_dividend(a4), .i_divisor(b4), .i_flush(f4),
        .o_valid(o_valid4), .i_ready(rdy4),
        .o_quotient(q4), .o_remainder(r4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for o_ready, presents operands for one accepting edge, then scrambles them.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        while (!o_ready && guard < 40) begin
            tick();
            guard++;
        end
        n_total++;
        if (guard >= 40) $display("FAIL ready_wait: o_ready=%0b required 1", o_ready);
        else n_pass++;
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        tick();
        i_valid    = 1'b0;
        i_dividend = 16'hAAAA;
        i_divisor  = 16'h0003;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_result(input string name, input logic [15:0] q, input logic [15:0] r,
                                input int cycles, input int exp_cycles);
        n_total++;
        if (cycles !== exp_cycles) $display("FAIL %s latency: got %0d required %0d", name, cycles, exp_cycles);
        else n_pass++;
        n_total++;
        if (o_quotient !== q) $display("FAIL %s quotient: got %h required %h", name, o_quotient, q);
        else n_pass++;
        n_total++;
        if (o_remainder !== r) $display("FAIL %s remainder: got %h required %h", name, o_remainder, r);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({o_ready, o_valid, o_quotient, o_remainder} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h required 1 0 0000 0000",
                     o_ready, o_valid, o_quotient, o_remainder);
        else n_pass++;
        n_total++;
        if ({o_ready4, o_valid4, q4, r4} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL reset_state4: got rdy=%b vld=%b q=%h r=%h required 1 0 0000 0000",
                     o_ready4, o_valid4, q4, r4);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        i_ready = 1'b1;
        issue(16'd100, 16'd7);
        n_total++;
        if (o_ready !== 1'b0) $display("FAIL busy_ready: got %b required 0", o_ready);
        else n_pass++;
        wait_valid(cyc);
        check_result("div_100_7", 16'd14, 16'd2, cyc, 16);
        tick();
        n_total++;
        if ({o_ready, o_valid, o_quotient} !== {1'b1, 1'b0, 16'h0})
            $display("FAIL handoff_idle: got rdy=%b vld=%b q=%h required 1 0 0000", o_ready, o_valid, o_quotient);
        else n_pass++;
    endtask

    task automatic test_patterns();
        int cyc;
        issue(16'hFFFF, 16'h0001);
        wait_valid(cyc);
        check_result("div_ffff_1", 16'hFFFF, 16'h0000, cyc, 16);
        issue(16'h1234, 16'h1235);
        wait_valid(cyc);
        check_result("div_1234_1235", 16'h0000, 16'h1234, cyc, 16);
    endtask

    task automatic test_div_zero();
        int cyc;
        issue(16'd5, 16'd0);
        wait_valid(cyc);
        check_result("div_by_zero", 16'h0000, 16'h0000, cyc, 0);
        tick();
        n_total++;
        if (o_ready !== 1'b1) $display("FAIL div_zero_idle: got rdy=%b required 1", o_ready);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc;
        i_ready = 1'b0;
        issue(16'd1000, 16'd3);
        wait_valid(cyc);
        check_result("div_1000_3", 16'd333, 16'd1, cyc, 16);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if ({o_valid, o_ready, o_quotient, o_remainder} !== {1'b1, 1'b0, 16'd333, 16'd1})
                $display("FAIL hold_%0d: got vld=%b rdy=%b q=%0d r=%0d required 1 0 333 1",
                         k, o_valid, o_ready, o_quotient, o_remainder);
            else n_pass++;
        end
        i_ready = 1'b1;
        tick();
        n_total++;
        if ({o_ready, o_valid} !== 2'b10) $display("FAIL hold_release: got rdy=%b vld=%b required 1 0", o_ready, o_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        issue(16'd50000, 16'd7);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({o_valid, o_ready, o_quotient, o_remainder} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL mid_run_reset: got vld=%b rdy=%b q=%h r=%h required 0 1 0000 0000",
                     o_valid, o_ready, o_quotient, o_remainder);
        else n_pass++;
        issue(16'd9, 16'd10);
        wait_valid(cyc);
        check_result("div_9_10", 16'd0, 16'd9, cyc, 16);
        tick();
    endtask

    task automatic test_flush();
        issue(16'd100, 16'd7);
        repeat (3) tick();
        i_flush    = 1'b1;
        i_valid    = 1'b1;
        i_dividend = 16'd20;
        i_divisor  = 16'd4;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        n_total++;
        if ({o_ready, o_valid, o_quotient} !== {1'b1, 1'b0, 16'h0})
            $display("FAIL flush_idle: got rdy=%b vld=%b q=%h required 1 0 0000", o_ready, o_valid, o_quotient);
        else n_pass++;
        tick();
        n_total++;
        if ({o_ready, o_valid} !== 2'b10)
            $display("FAIL flush_no_accept: got rdy=%b vld=%b required 1 0", o_ready, o_valid);
        else n_pass++;
    endtask

    task automatic test_radix16();
        int cyc = 0;
        a4   = 16'd200;
        b4   = 16'd9;
        v4   = 1'b1;
        tick();
        v4   = 1'b0;
        a4   = 16'h5555;
        b4   = 16'h0002;
        while (!o_valid4 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_total++;
        if (cyc !== 4) $display("FAIL r16_latency: got %0d required 4", cyc);
        else n_pass++;
        n_total++;
        if ({q4, r4} !== {16'd22, 16'd2}) $display("FAIL r16_200_9: got q=%0d r=%0d required 22 2", q4, r4);
        else n_pass++;
        tick();
        n_total++;
        if ({o_ready4, o_valid4} !== 2'b10) $display("FAIL r16_idle: got rdy=%b vld=%b required 1 0", o_ready4, o_valid4);
        else n_pass++;
    endtask

    initial begin
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_flush    = 1'b0;
        i_ready    = 1'b1;
        i_dividend = '0;
        i_divisor  = '0;
        v4         = 1'b0;
        f4         = 1'b0;
        rdy4       = 1'b1;
        a4         = '0;
        b4         = '0;

        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_flush();
        test_radix16();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
